cmd_exec: RTL and testbench
===========================

# cmd_exec

Consumer end of the command stream: accepts the single-cycle `cmd`/`cmd_arg0`/`cmd_valid` pulses produced by the board-level command generator, buffers them in a small FIFO and executes them one at a time against the life engine through a request/done handshake. It expands multi-step commands into repeated engine operations (ADVANCE by N generations), returns READ_CELL results and keeps a running generation count. It sits between command generation and the life engine core.

## Interface
- `FIFO_DEPTH`, 4: command buffer entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd`  in  3  command code, encodings from `command.vh`.
- `cmd_arg0`  in  32  command argument.
- `cmd_valid`  in  1  one-cycle strobe; no backpressure to the producer.
- `eng_op`  out  2  engine operation: `ENG_OP_SEED`, `ENG_OP_STEP`, `ENG_OP_READ`.
- `eng_arg`  out  32  operation argument; seed value for SEED, 0 otherwise.
- `eng_req`  out  1  request; held high until `eng_done`.
- `eng_done`  in  1  one-cycle completion strobe from engine.
- `eng_rdata`  in  1  cell value, valid with `eng_done` of a READ.
- `cell_value`  out  1  last READ_CELL result, held.
- `cell_valid`  out  1  one-cycle strobe when `cell_value` updates.
- `busy`  out  1  high when FIFO non-empty or FSM not IDLE.
- `overflow`  out  1  sticky: a command was dropped because FIFO full.
- `bad_cmd`  out  1  sticky: an unknown command code was dequeued.
- `gen_count`  out  32  completed STEP operations since reset, wraps.

## Operation
- Push: `cmd_valid` high and FIFO not full (or full with a pop in the same cycle) → entry written. Full with no pop → command dropped, `overflow` set.
- FSM states IDLE, REQ, DONE.
- IDLE: FIFO non-empty → pop head, decode:
  - CMD_SEED: op SEED, arg = `cmd_arg0`, remaining = 1 → REQ.
  - CMD_ADVANCE: op STEP, remaining = `cmd_arg0`; remaining 0 → stay IDLE (no-op).
  - CMD_READ_CELL: op READ, remaining = 1 → REQ.
  - other code: set `bad_cmd`, stay IDLE.
- REQ: `eng_req`=1, `eng_op`/`eng_arg` stable. On `eng_done`: decrement remaining (32-bit), STEP increments `gen_count`, READ loads `cell_value` and pulses `cell_valid` → DONE.
- DONE: `eng_req`=0 for exactly one cycle; remaining ≠ 0 → REQ, else IDLE.
- `eng_done` outside REQ ignored.
- Reset mid-operation: FIFO emptied, FSM → IDLE, remaining/op discarded; engine is reset by the same `reset`.

## Timing
- Reset values: `eng_req` 0, `eng_op` STEP, `eng_arg` 0, `cell_value` 0, `cell_valid` 0, `busy` 0, `overflow` 0, `bad_cmd` 0, `gen_count` 0.
- All outputs registered.
- `cmd_valid` at cycle t into empty idle block → pop at t+1, `eng_req` high from t+2.
- `eng_done` at cycle d → `eng_req` low at d+1 (DONE), next request high at d+2.
- ADVANCE N: N request/done pairs, each separated by one low cycle.
- `cell_valid` and `gen_count` update at d+1.
- `busy` high from cycle after push until FSM returns to IDLE with FIFO empty.

## Configuration
- `CMD_EXEC_GEN_COUNT_EN` defined: `gen_count` counter built as above.
- Undefined: no counter; `gen_count` tied to 32'b0; all other behaviour identical.

## Structure
- `command.vh`: existing `CMD_SEED`, `CMD_ADVANCE`, `CMD_READ_CELL`; add `ENG_OP_SEED`=2'd0, `ENG_OP_STEP`=2'd1, `ENG_OP_READ`=2'd2.
- Sub-module `cmd_fifo`: synchronous FIFO, 35-bit entries, depth `FIFO_DEPTH`, push/pop/full/empty, simultaneous push+pop when full allowed.
- FSM, remaining counter, status registers in `cmd_exec`.

## Test plan
- SEED arg 32'h1234_5678, engine done after 3 cycles → one request, `eng_op`=SEED, `eng_arg`=32'h1234_5678, `busy` low after DONE.
- ADVANCE arg 3 → three STEP requests, one low cycle between; `gen_count` 0→3; ADVANCE arg 0 → no request.
- READ_CELL with `eng_rdata`=1 at done → `cell_value`=1, `cell_valid` pulsed once at done+1.
- Engine stalled, 6 pulses with `FIFO_DEPTH`=4 → first popped, 4 buffered, 6th dropped, `overflow`=1; remaining 5 execute in order.
- Dequeue code 3'b111 → `bad_cmd`=1, no request; reset asserted during ADVANCE 100 → all outputs at reset values next cycle, no further requests.

Source files
------------

// File: rtl/cmd_exec_pkg.sv
// Shared types and encodings for the command executor: command codes,
// engine operation codes, FIFO entry layout and FSM state type.
package cmd_exec_pkg;

  localparam logic [2:0] CMD_SEED      = 3'd1;
  localparam logic [2:0] CMD_ADVANCE   = 3'd2;
  localparam logic [2:0] CMD_READ_CELL = 3'd3;

  localparam logic [1:0] ENG_OP_SEED = 2'd0;
  localparam logic [1:0] ENG_OP_STEP = 2'd1;
  localparam logic [1:0] ENG_OP_READ = 2'd2;

  localparam int ENTRY_W = 35;

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] arg;
  } cmd_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered pointers and occupancy count;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
module cmd_fifo
  import cmd_exec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       wr_data,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_exec.sv
// Command executor: buffers command strobes and runs them against the life
// engine one operation at a time. CMD_EXEC_GEN_COUNT_EN builds gen_count.
//
// state | meaning
// IDLE  | waiting for a buffered command; pops and decodes the head
// REQ   | eng_req high, waiting for eng_done
// DONE  | one low cycle between requests; repeat while remaining != 0
module cmd_exec
  import cmd_exec_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cmd,
  input  logic [31:0] cmd_arg0,
  input  logic        cmd_valid,
  output logic [1:0]  eng_op,
  output logic [31:0] eng_arg,
  output logic        eng_req,
  input  logic        eng_done,
  input  logic        eng_rdata,
  output logic        cell_value,
  output logic        cell_valid,
  output logic        busy,
  output logic        overflow,
  output logic        bad_cmd,
  output logic [31:0] gen_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        remaining;
  logic [31:0]        remaining_nxt;
  logic [1:0]         op_nxt;
  logic [31:0]        arg_nxt;
  logic               cell_value_nxt;
  logic               cell_valid_nxt;
  logic               bad_cmd_nxt;
  logic               busy_nxt;
  logic               nonempty_nxt;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  cmd_entry_t         head;

  assign fifo_wr_data = {cmd, cmd_arg0};
  assign head         = cmd_entry_t'(fifo_rd_data);

  // No backpressure: a strobe into a full FIFO survives only if the head leaves this cycle.
  assign push         = cmd_valid && (!fifo_full || pop);
  assign nonempty_nxt = push || (fifo_count > CNT_W'(pop));
  assign busy_nxt     = nonempty_nxt || (state_nxt != ST_IDLE);

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (fifo_wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt      = state;
    remaining_nxt  = remaining;
    op_nxt         = eng_op;
    arg_nxt        = eng_arg;
    cell_value_nxt = cell_value;
    cell_valid_nxt = 1'b0;
    bad_cmd_nxt    = bad_cmd;
    pop            = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          case (head.code)
            CMD_SEED: begin
              op_nxt        = ENG_OP_SEED;
              arg_nxt       = head.arg;
              remaining_nxt = 32'd1;
              state_nxt     = ST_REQ;
            end
            CMD_ADVANCE: begin
              op_nxt        = ENG_OP_STEP;
              arg_nxt       = 32'd0;
              remaining_nxt = head.arg;
              if (head.arg != 32'd0) begin
                state_nxt = ST_REQ;
              end
            end
            CMD_READ_CELL: begin
              op_nxt        = ENG_OP_READ;
              arg_nxt       = 32'd0;
              remaining_nxt = 32'd1;
              state_nxt     = ST_REQ;
            end
            default: begin
              bad_cmd_nxt = 1'b1;
            end
          endcase
        end
      end
      ST_REQ: begin
        if (eng_done) begin
          remaining_nxt = remaining - 32'd1;
          state_nxt     = ST_DONE;
          if (eng_op == ENG_OP_READ) begin
            cell_value_nxt = eng_rdata;
            cell_valid_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = (remaining != 32'd0) ? ST_REQ : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      eng_op     <= ENG_OP_STEP;
      eng_arg    <= '0;
      eng_req    <= 1'b0;
      cell_value <= 1'b0;
      cell_valid <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bad_cmd    <= 1'b0;
    end else begin
      state      <= state_nxt;
      remaining  <= remaining_nxt;
      eng_op     <= op_nxt;
      eng_arg    <= arg_nxt;
      eng_req    <= (state_nxt == ST_REQ);
      cell_value <= cell_value_nxt;
      cell_valid <= cell_valid_nxt;
      busy       <= busy_nxt;
      overflow   <= overflow | (cmd_valid && fifo_full && !pop);
      bad_cmd    <= bad_cmd_nxt;
    end
  end

`ifdef CMD_EXEC_GEN_COUNT_EN
  logic        step_done;
  logic [31:0] gen_count_q;

  assign step_done = (state == ST_REQ) && eng_done && (eng_op == ENG_OP_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      gen_count_q <= '0;
    end else if (step_done) begin
      gen_count_q <= gen_count_q + 32'd1;
    end
  end

  assign gen_count = gen_count_q;
`else
  assign gen_count = 32'b0;
`endif

endmodule

// File: tb/tb_cmd_exec.sv
// Self-checking bench for cmd_exec: directed scenarios plus randomized
// command bursts checked against a queue-based model of expected engine ops.
module tb_cmd_exec;
  import cmd_exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  cmd;
  logic [31:0] cmd_arg0;
  logic        cmd_valid;
  logic [1:0]  eng_op;
  logic [31:0] eng_arg;
  logic        eng_req;
  logic        eng_done;
  logic        eng_rdata;
  logic        cell_value;
  logic        cell_valid;
  logic        busy;
  logic        overflow;
  logic        bad_cmd;
  logic [31:0] gen_count;

  always #5 clk = ~clk;

  cmd_exec #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_arg0   (cmd_arg0),
    .cmd_valid  (cmd_valid),
    .eng_op     (eng_op),
    .eng_arg    (eng_arg),
    .eng_req    (eng_req),
    .eng_done   (eng_done),
    .eng_rdata  (eng_rdata),
    .cell_value (cell_value),
    .cell_valid (cell_valid),
    .busy       (busy),
    .overflow   (overflow),
    .bad_cmd    (bad_cmd),
    .gen_count  (gen_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: each accepted command expands into a list of engine ops.
  typedef struct {
    logic [1:0]  op;
    logic [31:0] arg;
    bit          chained;
  } op_t;

  op_t         exp_q[$];
  logic [31:0] m_gen  = 0;
  logic        m_cell = 0;
  bit          m_bad  = 0;

  task automatic model_cmd(input logic [2:0] code, input logic [31:0] arg);
    op_t e;
    if (code == CMD_SEED) begin
      e.op = ENG_OP_SEED; e.arg = arg; e.chained = 0;
      exp_q.push_back(e);
    end else if (code == CMD_ADVANCE) begin
      for (int i = 0; i < int'(arg); i++) begin
        e.op = ENG_OP_STEP; e.arg = 0; e.chained = (i != 0);
        exp_q.push_back(e);
      end
    end else if (code == CMD_READ_CELL) begin
      e.op = ENG_OP_READ; e.arg = 0; e.chained = 0;
      exp_q.push_back(e);
    end else begin
      m_bad = 1;
    end
  endtask

  function automatic logic [31:0] exp_gen_count();
`ifdef CMD_EXEC_GEN_COUNT_EN
    return m_gen;
`else
    return 32'd0;
`endif
  endfunction

  // Engine responder and protocol monitor share one negedge process.
  bit         mon_en    = 0;
  bit         eng_stall = 0;
  bit         spur_en   = 0;
  bit         lat_rand  = 0;
  int         lat_fixed = 3;
  int         rd_mode   = 2;
  int         lat       = 3;
  int         hold      = 0;
  int         low_run   = 0;
  int         n_req     = 0;
  int         n_cv      = 0;
  logic       done_drv  = 0;
  logic       rd_drv    = 0;
  logic       req_seen  = 0;
  logic [1:0] cur_op    = ENG_OP_STEP;

  initial begin
    logic acc;
    op_t  e;
    eng_done  = 1'b0;
    eng_rdata = 1'b0;
    forever begin
      @(negedge clk);
      acc = done_drv && req_seen && !reset;
      if (mon_en) begin
        if (acc) begin
          check_val("req_low_after_done", eng_req, 0);
          if (cur_op == ENG_OP_STEP) m_gen = m_gen + 1;
          if (cur_op == ENG_OP_READ) m_cell = rd_drv;
          check_val("gen_count", gen_count, exp_gen_count());
        end
        if (acc || cell_valid) begin
          check_val("cell_valid", cell_valid, acc && (cur_op == ENG_OP_READ));
          check_val("cell_value", cell_value, m_cell);
        end
      end
      if (cell_valid) n_cv++;
      if (eng_req && !req_seen) begin
        n_req++;
        hold = 0;
        lat  = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
        if (mon_en) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_req", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("req_op", eng_op, e.op);
            check_val("req_arg", eng_arg, e.arg);
            if (e.chained) check_val("step_gap", low_run, 1);
            cur_op = e.op;
          end
        end
      end
      low_run = eng_req ? 0 : low_run + 1;
      done_drv = 1'b0;
      if (eng_req && !eng_stall) begin
        hold++;
        if (hold >= lat) begin
          done_drv = 1'b1;
          rd_drv   = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : rd_mode[0];
        end
      end else if (!eng_req && spur_en && $urandom_range(0, 5) == 0) begin
        done_drv = 1'b1;
        rd_drv   = 1'($urandom_range(0, 1));
      end
      eng_done  = done_drv;
      eng_rdata = rd_drv;
      req_seen  = eng_req;
    end
  end

  task automatic send(input logic [2:0] code, input logic [31:0] arg);
    @(negedge clk);
    cmd = code; cmd_arg0 = arg; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || eng_req || exp_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy || eng_req || exp_q.size() != 0) check_val("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_eng_req", eng_req, 0);
    check_val("rst_eng_op", eng_op, ENG_OP_STEP);
    check_val("rst_eng_arg", eng_arg, 0);
    check_val("rst_cell_value", cell_value, 0);
    check_val("rst_cell_valid", cell_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_bad_cmd", bad_cmd, 0);
    check_val("rst_gen_count", gen_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int r0;
    int cv0;
    logic [2:0]  code;
    logic [31:0] arg;
    int blen;

    reset = 1'b1; cmd = 3'd0; cmd_arg0 = 32'd0; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    mon_en = 1;

    // SEED with cycle-level timing, engine answers on the third request cycle
    model_cmd(CMD_SEED, 32'h1234_5678);
    @(negedge clk);
    cmd = CMD_SEED; cmd_arg0 = 32'h1234_5678; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_val("seed_busy_t1", busy, 1);
    check_val("seed_req_t1", eng_req, 0);
    @(negedge clk);
    check_val("seed_req_t2", eng_req, 1);
    k = 0;
    while (eng_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("seed_req_cycles", k, 3);
    check_val("seed_busy_done", busy, 1);
    @(negedge clk);
    check_val("seed_busy_idle", busy, 0);
    check_val("seed_req_idle", eng_req, 0);
    wait_idle(50);

    // ADVANCE 3, then ADVANCE 0
    r0 = n_req;
    model_cmd(CMD_ADVANCE, 3);
    send(CMD_ADVANCE, 3);
    wait_idle(100);
    check_val("adv3_reqs", n_req - r0, 3);
    check_val("adv3_gen", gen_count, exp_gen_count());
    r0 = n_req;
    model_cmd(CMD_ADVANCE, 0);
    send(CMD_ADVANCE, 0);
    wait_idle(50);
    check_val("adv0_reqs", n_req - r0, 0);
    check_val("adv0_busy", busy, 0);

    // READ_CELL returning 1
    rd_mode = 1;
    cv0 = n_cv;
    model_cmd(CMD_READ_CELL, 0);
    send(CMD_READ_CELL, 32'hdead_beef);
    wait_idle(50);
    check_val("read_cell_value", cell_value, 1);
    check_val("read_cv_pulses", n_cv - cv0, 1);
    rd_mode = 2;

    // Stalled engine: six back-to-back strobes, the sixth is dropped
    check_val("ovf_pre", overflow, 0);
    eng_stall = 1;
    model_cmd(CMD_SEED, 32'h0000_00a1);
    model_cmd(CMD_READ_CELL, 0);
    model_cmd(CMD_ADVANCE, 2);
    model_cmd(CMD_SEED, 32'h0000_00b2);
    model_cmd(CMD_READ_CELL, 0);
    @(negedge clk); cmd = CMD_SEED;      cmd_arg0 = 32'h0000_00a1; cmd_valid = 1'b1;
    @(negedge clk); cmd = CMD_READ_CELL; cmd_arg0 = 32'd0;
    @(negedge clk); cmd = CMD_ADVANCE;   cmd_arg0 = 32'd2;
    @(negedge clk); cmd = CMD_SEED;      cmd_arg0 = 32'h0000_00b2;
    @(negedge clk); cmd = CMD_READ_CELL; cmd_arg0 = 32'd0;
    @(negedge clk); cmd = CMD_SEED;      cmd_arg0 = 32'h0000_00c3;
    @(negedge clk); cmd_valid = 1'b0;
    check_val("ovf_set", overflow, 1);
    repeat (5) @(negedge clk);
    check_val("ovf_stall_req", eng_req, 1);
    eng_stall = 0;
    wait_idle(200);
    check_val("ovf_sticky", overflow, 1);
    check_val("ovf_gen", gen_count, exp_gen_count());

    // Unknown code
    r0 = n_req;
    send(3'b111, 32'h5);
    model_cmd(3'b111, 32'h5);
    wait_idle(50);
    check_val("bad_cmd_set", bad_cmd, 1);
    check_val("bad_cmd_reqs", n_req - r0, 0);

    // Reset in the middle of ADVANCE 100
    mon_en = 0;
    lat_fixed = 2;
    send(CMD_ADVANCE, 100);
    repeat (15) @(negedge clk);
    check_val("adv100_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    exp_q.delete();
    m_gen = 0; m_cell = 0; m_bad = 0;
    r0 = n_req;
    repeat (20) @(negedge clk);
    check_val("post_rst_reqs", n_req - r0, 0);
    check_val("post_rst_busy", busy, 0);
    mon_en = 1;

    // Randomized bursts, at most five strobes into an idle block so none drop
    spur_en = 1; lat_rand = 1; rd_mode = 2;
    for (int b = 0; b < 40; b++) begin
      blen = $urandom_range(1, 5);
      for (int i = 0; i < blen; i++) begin
        code = 3'($urandom_range(0, 7));
        arg  = (code == CMD_ADVANCE) ? 32'($urandom_range(0, 4)) : $urandom;
        model_cmd(code, arg);
        @(negedge clk);
        cmd = code; cmd_arg0 = arg; cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_idle(400);
      check_val("rnd_bad_cmd", bad_cmd, m_bad);
      check_val("rnd_overflow", overflow, 0);
      check_val("rnd_cell_value", cell_value, m_cell);
      check_val("rnd_gen_count", gen_count, exp_gen_count());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
